// File: rtl/reveal_ctrl_pkg.sv
// Shared constants for the minesweeper board: grid geometry, reveal FSM encoding
// and the fixed neighbour offset table used by the reveal sequencer.
package reveal_ctrl_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 16;
    localparam int X_W    = $clog2(GRID_W);
    localparam int Y_W    = $clog2(GRID_H);
    localparam int ADDR_W = X_W + Y_W;
    localparam int CNT_W  = 4;
    localparam int NBR_N  = 8;
    localparam int NBR_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK_REQ,
        S_CHK_WAIT,
        S_MINE,
        S_SCAN_REQ,
        S_SCAN_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    // Row-major neighbour walk: the row above, the same row, then the row below.
    localparam logic signed [1:0] NBR_DX [NBR_N] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
    localparam logic signed [1:0] NBR_DY [NBR_N] = '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};

endpackage

// File: rtl/reveal_ctrl_if.sv
// Mine-map read port (req/gnt) and reveal-map write port of the reveal sequencer.
interface reveal_ctrl_if;
    import reveal_ctrl_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rdata;
    logic              rev_wren;
    logic [ADDR_W-1:0] rev_addr;
    logic [CNT_W:0]    rev_data;

    modport master (
        output mem_req, mem_addr, rev_wren, rev_addr, rev_data,
        input  mem_gnt, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, rev_wren, rev_addr, rev_data,
        output mem_gnt, mem_rdata
    );

endinterface

// File: rtl/reveal_ctrl_nbr_addr_gen.sv
// Maps a base cell and neighbour index to the neighbour's address, flagging
// neighbours that fall off the board edge (no wrap-around).
module nbr_addr_gen
    import reveal_ctrl_pkg::*;
(
    input  logic [ADDR_W-1:0] i_base,
    input  logic [NBR_W-1:0]  i_nbr_idx,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr
);

    logic signed [1:0] w_dx;
    logic signed [1:0] w_dy;
    logic [X_W:0]      w_nx;
    logic [Y_W:0]      w_ny;

    assign w_dx = NBR_DX[i_nbr_idx];
    assign w_dy = NBR_DY[i_nbr_idx];

    // One extra bit: -1 and GRID both land with the top bit set, so it is the bounds flag.
    assign w_nx = {1'b0, i_base[X_W-1:0]} + {{(X_W-1){w_dx[1]}}, w_dx};
    assign w_ny = {1'b0, i_base[ADDR_W-1:X_W]} + {{(Y_W-1){w_dy[1]}}, w_dy};

    assign o_valid = !w_nx[X_W] && !w_ny[Y_W];
    assign o_addr  = {w_ny[Y_W-1:0], w_nx[X_W-1:0]};

endmodule

// File: rtl/reveal_ctrl.sv
// Single-square reveal sequencer: checks the selected cell for a mine, then counts
// mines among its in-bounds neighbours and writes {revealed, count} to the reveal map.
module reveal_ctrl
    import reveal_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [X_W-1:0]   i_cur_x,
    input  logic [Y_W-1:0]   i_cur_y,
    reveal_ctrl_if.master    bus,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_hit_mine
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_count;
    logic [NBR_W-1:0]  r_nbr_idx;
    logic              r_hit_mine;

    logic              w_nbr_valid;
    logic [ADDR_W-1:0] w_nbr_addr;
    logic              w_last;
    logic              w_accept;
    logic              w_cnt_inc;
    logic              w_idx_inc;
    logic              w_idx_clr;
    logic              w_set_hit;
    logic              w_mem_req;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_rev_wren;

    nbr_addr_gen u_nbr_addr_gen (
        .i_base    (r_base),
        .i_nbr_idx (r_nbr_idx),
        .o_valid   (w_nbr_valid),
        .o_addr    (w_nbr_addr)
    );

    assign w_last = (r_nbr_idx == NBR_W'(NBR_N - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cnt_inc   = 1'b0;
        w_idx_inc   = 1'b0;
        w_idx_clr   = 1'b0;
        w_set_hit   = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_addr  = '0;
        w_rev_wren  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CHK_REQ;
                end
            end
            S_CHK_REQ: begin
                w_mem_req  = 1'b1;
                w_mem_addr = r_base;
                if (bus.mem_gnt) w_state_nxt = S_CHK_WAIT;
            end
            S_CHK_WAIT: begin
                if (bus.mem_rdata) begin
                    w_state_nxt = S_MINE;
                end else begin
                    w_idx_clr   = 1'b1;
                    w_state_nxt = S_SCAN_REQ;
                end
            end
            S_MINE: begin
                w_set_hit   = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_SCAN_REQ: begin
                if (w_nbr_valid) begin
                    w_mem_req  = 1'b1;
                    w_mem_addr = w_nbr_addr;
                    if (bus.mem_gnt) w_state_nxt = S_SCAN_WAIT;
                end else if (w_last) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_idx_inc = 1'b1;
                end
            end
            S_SCAN_WAIT: begin
                w_cnt_inc = bus.mem_rdata;
                if (w_last) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_idx_inc   = 1'b1;
                    w_state_nxt = S_SCAN_REQ;
                end
            end
            S_WRITE: begin
                w_rev_wren  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_count    <= '0;
            r_nbr_idx  <= '0;
            r_hit_mine <= 1'b0;
        end else begin
            if (w_accept) begin
                r_base     <= {i_cur_y, i_cur_x};
                r_count    <= '0;
                r_nbr_idx  <= '0;
                r_hit_mine <= 1'b0;
            end
            if (w_set_hit) r_hit_mine <= 1'b1;
            if (w_cnt_inc) r_count <= r_count + CNT_W'(1);
            if (w_idx_clr)      r_nbr_idx <= '0;
            else if (w_idx_inc) r_nbr_idx <= r_nbr_idx + NBR_W'(1);
        end
    end

    assign bus.mem_req  = w_mem_req;
    assign bus.mem_addr = w_mem_addr;
    assign bus.rev_wren = w_rev_wren;
    assign bus.rev_addr = w_rev_wren ? r_base : '0;
    assign bus.rev_data = w_rev_wren ? {1'b1, r_count} : '0;

    assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done     = (r_state == S_DONE);
    assign o_hit_mine = r_hit_mine;

endmodule
